// File: rtl/multicycle_controller.sv
// Moore FSM that sequences a multicycle RV32I datapath (shared ALU, unified memory).
// Optional feature macro ILLEGAL_TRAP_EN: unknown opcodes trap into a sticky ERROR state.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic               zero,
  input  logic               lt,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [2:0]         ImmSrc,
  output logic               RegWrite,
  output logic               instr_done,
`ifdef ILLEGAL_TRAP_EN
  output logic               illegal,
`endif
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 'd0,
    S_DECODE = 'd1,
    S_MEMADR = 'd2,
    S_MEMRD  = 'd3,
    S_MEMWB  = 'd4,
    S_MEMWR  = 'd5,
    S_EXER   = 'd6,
    S_EXEI   = 'd7,
    S_ALUWB  = 'd8,
    S_JAL    = 'd9,
    S_JALR1  = 'd10,
    S_JALR2  = 'd11,
    S_BRANCH = 'd12,
    S_LUI    = 'd13,
    S_ERROR  = 'd14
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  state_t state_q, state_d;

  // Only funct7[5] carries meaning here (sub vs add); the other bits are don't-care.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // sltu shares the slt encoding and sra degrades to srl: the ALU has no unsigned or arithmetic shift op.
  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub_en);
    case (f3)
      3'b000:  alu_dec = sub_en ? ALU_SUB : ALU_ADD;
      3'b001:  alu_dec = ALU_SLL;
      3'b010:  alu_dec = ALU_SLT;
      3'b011:  alu_dec = ALU_SLT;
      3'b100:  alu_dec = ALU_XOR;
      3'b101:  alu_dec = ALU_SRL;
      3'b110:  alu_dec = ALU_OR;
      default: alu_dec = ALU_AND;
    endcase
  endfunction

  logic br_taken;
  always_comb begin
    case (funct3)
      3'b000:  br_taken = zero;
      3'b001:  br_taken = ~zero;
      3'b100:  br_taken = lt;
      3'b101:  br_taken = ~lt;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE: ImmSrc = IMM_S;
      OP_BR:    ImmSrc = IMM_B;
      OP_JAL:   ImmSrc = IMM_J;
      OP_LUI:   ImmSrc = IMM_U;
      default:  ImmSrc = IMM_I;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  assign state_o = state_q;

  always_comb begin
    state_d    = state_q;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    RegWrite   = 1'b0;
    instr_done = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal    = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // Branch/jal target is precomputed here into ALUOut.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXER;
          OP_I:              state_d = S_EXEI;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR1;
          OP_BR:             state_d = S_BRANCH;
          OP_LUI:            state_d = S_LUI;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_d    = S_ERROR;
`else
            instr_done = 1'b1;
            state_d    = S_FETCH;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_LOAD) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXER: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUControl = alu_dec(funct3, funct7[5]);
        state_d    = S_ALUWB;
      end
      S_EXEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec(funct3, 1'b0);
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc  = 2'b00;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // PC takes the DECODE target while the ALU forms the link value OldPC+4.
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b00;
        PCWrite   = 1'b1;
        state_d   = S_ALUWB;
      end
      S_JALR1: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = S_JALR2;
      end
      S_JALR2: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b00;
        PCWrite   = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_SUB;
        ResultSrc  = 2'b00;
        PCWrite    = br_taken;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_LUI: begin
        ResultSrc  = 2'b11;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      S_ERROR: begin
        illegal = 1'b1;
        state_d = S_ERROR;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    // Reset presents FETCH selects with every strobe suppressed.
    if (rst) begin
      state_d    = S_FETCH;
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      ResultSrc  = 2'b10;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b10;
      ALUControl = ALU_ADD;
      RegWrite   = 1'b0;
      instr_done = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal    = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected outputs queued by stimulus, checked by a monitor.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero, lt;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;
  logic [3:0] state_o;
  logic       ill_w;

  always #5 clk = ~clk;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .lt(lt), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .instr_done(instr_done),
`ifdef ILLEGAL_TRAP_EN
    .illegal(ill_w),
`endif
    .state_o(state_o)
  );

`ifndef ILLEGAL_TRAP_EN
  assign ill_w = 1'b0;
`endif

  typedef struct packed {
    logic [22:0] v;
    logic        st_care;
    logic [15:0] id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;

  exp_t        e_m;
  logic [22:0] act_m, mask_m;

  // Monitor: one expected record per cycle, compared away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_m    = exp_q.pop_front();
      act_m  = {state_o, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ALUControl, ImmSrc, RegWrite, instr_done, ill_w};
      mask_m = e_m.st_care ? 23'h7FFFFF : 23'h07FFFF;
      checks++;
      if ((act_m & mask_m) !== (e_m.v & mask_m)) begin
        errors++;
        $display("FAIL step%0d outputs: actual=%h required=%h (mask %h)",
                 e_m.id, act_m, e_m.v, mask_m);
      end
    end
  end

  // Queue expected outputs for the current cycle, then advance one cycle.
  task automatic c(input int st, input bit pcw, adr, mw, irw,
                   input bit [1:0] res, a, b, input bit [2:0] alu, imm,
                   input bit rw, dn, il);
    exp_t e;
    logic [3:0] s4;
    s4        = st[3:0];
    e.v       = {s4, pcw, adr, mw, irw, res, a, b, alu, imm, rw, dn, il};
    e.st_care = (st >= 0);
    e.id      = step[15:0];
    step++;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    op = o; funct3 = f3; funct7 = f7;
  endtask

  task automatic fetch(input bit [2:0] imm);
    c(0, 1,0,0,1, 2'b10,2'b00,2'b10, 3'b000, imm, 0,0,0);
  endtask

  task automatic decode(input bit [2:0] imm);
    c(1, 0,0,0,0, 2'b00,2'b01,2'b01, 3'b000, imm, 0,0,0);
  endtask

  task automatic aluwb(input bit [2:0] imm);
    c(8, 0,0,0,0, 2'b00,2'b00,2'b00, 3'b000, imm, 1,1,0);
  endtask

  task automatic r_op(input logic [2:0] f3, input logic [6:0] f7, input bit [2:0] alu);
    instr(7'b0110011, f3, f7);
    fetch(3'b000); decode(3'b000);
    c(6, 0,0,0,0, 2'b00,2'b10,2'b00, alu, 3'b000, 0,0,0);
    aluwb(3'b000);
  endtask

  task automatic i_op(input logic [2:0] f3, input logic [6:0] f7, input bit [2:0] alu);
    instr(7'b0010011, f3, f7);
    fetch(3'b000); decode(3'b000);
    c(7, 0,0,0,0, 2'b00,2'b10,2'b01, alu, 3'b000, 0,0,0);
    aluwb(3'b000);
  endtask

  task automatic br(input logic [2:0] f3, input logic z, input logic l, input bit taken);
    instr(7'b1100011, f3, 7'h00);
    zero = z; lt = l;
    fetch(3'b010); decode(3'b010);
    c(12, taken,0,0,0, 2'b00,2'b10,2'b00, 3'b001, 3'b010, 0,1,0);
    zero = 1'b0; lt = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; zero = 1'b0; lt = 1'b0;
    instr(7'b0110011, 3'b000, 7'h00);
    @(posedge clk); #1;
    // reset: FETCH selects, strobes low
    c(0, 0,0,0,0, 2'b10,2'b00,2'b10, 3'b000, 3'b000, 0,0,0);
    rst = 1'b0;

    r_op(3'b000, 7'h00, 3'b000);  // add x3,x1,x2
    r_op(3'b000, 7'h20, 3'b001);  // sub
    r_op(3'b101, 7'h20, 3'b111);  // sra -> srl
    r_op(3'b110, 7'h00, 3'b011);  // or
    r_op(3'b111, 7'h00, 3'b010);  // and
    r_op(3'b001, 7'h00, 3'b110);  // sll
    i_op(3'b010, 7'h00, 3'b101);  // slti
    i_op(3'b000, 7'h20, 3'b000);  // addi ignores funct7
    i_op(3'b101, 7'h20, 3'b111);  // srai -> srl
    i_op(3'b100, 7'h00, 3'b100);  // xori

    // lw
    instr(7'b0000011, 3'b010, 7'h00);
    fetch(3'b000); decode(3'b000);
    c(2, 0,0,0,0, 2'b00,2'b10,2'b01, 3'b000, 3'b000, 0,0,0);
    c(3, 0,1,0,0, 2'b00,2'b00,2'b00, 3'b000, 3'b000, 0,0,0);
    c(4, 0,0,0,0, 2'b01,2'b00,2'b00, 3'b000, 3'b000, 1,1,0);

    // sw
    instr(7'b0100011, 3'b010, 7'h00);
    fetch(3'b001); decode(3'b001);
    c(2, 0,0,0,0, 2'b00,2'b10,2'b01, 3'b000, 3'b001, 0,0,0);
    c(5, 0,1,1,0, 2'b00,2'b00,2'b00, 3'b000, 3'b001, 0,1,0);

    br(3'b000, 1'b1, 1'b0, 1'b1);  // beq taken
    br(3'b000, 1'b0, 1'b0, 1'b0);  // beq not taken
    br(3'b100, 1'b0, 1'b1, 1'b1);  // blt taken
    br(3'b101, 1'b0, 1'b1, 1'b0);  // bge not taken
    br(3'b001, 1'b0, 1'b0, 1'b1);  // bne taken
    br(3'b010, 1'b1, 1'b1, 1'b0);  // undefined funct3 never taken

    // jal
    instr(7'b1101111, 3'b000, 7'h00);
    fetch(3'b011); decode(3'b011);
    c(9, 1,0,0,0, 2'b00,2'b01,2'b10, 3'b000, 3'b011, 0,0,0);
    aluwb(3'b011);

    // jalr
    instr(7'b1100111, 3'b000, 7'h00);
    fetch(3'b000); decode(3'b000);
    c(10, 0,0,0,0, 2'b00,2'b10,2'b01, 3'b000, 3'b000, 0,0,0);
    c(11, 1,0,0,0, 2'b00,2'b01,2'b10, 3'b000, 3'b000, 0,0,0);
    aluwb(3'b000);

    // lui
    instr(7'b0110111, 3'b000, 7'h00);
    fetch(3'b100); decode(3'b100);
    c(13, 0,0,0,0, 2'b11,2'b00,2'b00, 3'b000, 3'b100, 1,1,0);

    // sw aborted by reset in MEMWR
    instr(7'b0100011, 3'b010, 7'h00);
    fetch(3'b001); decode(3'b001);
    c(2, 0,0,0,0, 2'b00,2'b10,2'b01, 3'b000, 3'b001, 0,0,0);
    rst = 1'b1;
    c(-1, 0,0,0,0, 2'b10,2'b00,2'b10, 3'b000, 3'b001, 0,0,0);
    rst = 1'b0;

    // illegal opcode 0x7F
    instr(7'h7F, 3'b000, 7'h00);
    fetch(3'b000);
`ifdef ILLEGAL_TRAP_EN
    decode(3'b000);
    c(14, 0,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 3'b000, 0,0,1);
    c(14, 0,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 3'b000, 0,0,1);
    c(14, 0,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 3'b000, 0,0,1);
    rst = 1'b1;
    c(-1, 0,0,0,0, 2'b10,2'b00,2'b10, 3'b000, 3'b000, 0,0,0);
    rst = 1'b0;
`else
    c(1, 0,0,0,0, 2'b00,2'b01,2'b01, 3'b000, 3'b000, 0,1,0);
`endif

    // lui right after: must start in FETCH
    instr(7'b0110111, 3'b000, 7'h00);
    fetch(3'b100); decode(3'b100);
    c(13, 0,0,0,0, 2'b11,2'b00,2'b00, 3'b000, 3'b100, 1,1,0);

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
